// File: rtl/lif_pkg.sv
// Shared types and defaults for the lif spike monitor.
// Imported by the monitor top and its accumulators.
package lif_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DIR_N = 0;
  localparam int DIR_E = 1;
  localparam int DIR_S = 2;
  localparam int DIR_W = 3;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_WIN_LEN   = 64;
  localparam int DEF_QUIET_LEN = 16;

endpackage

// File: rtl/lif_spike_monitor_if.sv
// Result handshake bundle of the spike monitor.
// The monitor is master; the consumer is slave.
interface lif_spike_monitor_if #(
  parameter int CNT_W = 8
) ();

  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;
  logic [CNT_W-1:0] cnt3;
  logic [3:0]       sat;

  modport master (
    output out_valid,
    output cnt0,
    output cnt1,
    output cnt2,
    output cnt3,
    output sat,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  cnt0,
    input  cnt1,
    input  cnt2,
    input  cnt3,
    input  sat,
    output out_ready
  );

endinterface

// File: rtl/lif_sat_counter.sv
// Saturating spike accumulator with sticky overflow flag.
// Clear has priority over increment.
module lif_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX = '1;

  // count up, pin at max and remember the overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (q == MAX) sat <= 1'b1;
      else          q   <= q + 1'b1;
    end
  end

endmodule

// File: rtl/lif_spike_monitor.sv
// Per-window spike counter and quiescence detector
// for a single lif cell, with a one-deep result buffer.
module lif_spike_monitor
  import lif_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int WIN_LEN   = DEF_WIN_LEN,
  parameter int QUIET_LEN = DEF_QUIET_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [3:0]          cell_state,
  output logic                dropped,
  output logic                quiet,
  lif_spike_monitor_if.master mon
);

  localparam int WC_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam int QC_W = $clog2(QUIET_LEN + 1);

  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WIN_LEN - 1);
  localparam logic [QC_W-1:0]  QC_MAX  = QC_W'(QUIET_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [WC_W-1:0]  r_wcnt;
  logic [QC_W-1:0]  r_qcnt;
  logic             r_quiet;
  logic             r_valid;
  logic             r_dropped;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       r_sat;

  logic             w_run;
  logic             w_last;
  logic             w_clr;
  logic [3:0]       w_inc;
  logic [CNT_W-1:0] w_acc [4];
  logic [3:0]       w_acc_sat;
  logic [CNT_W-1:0] w_fin [4];
  logic [3:0]       w_fin_sat;
  logic [QC_W-1:0]  w_qnext;

  assign w_run  = (r_state == COUNT) && enable;
  assign w_last = w_run && (r_wcnt == WC_LAST);
  assign w_clr  = !w_run || w_last;
  assign w_inc  = {4{w_run}} & cell_state;

  for (genvar g = 0; g < 4; g++) begin : g_acc
    lif_sat_counter #(
      .CNT_W (CNT_W)
    ) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (w_clr),
      .inc   (w_inc[g]),
      .q     (w_acc[g]),
      .sat   (w_acc_sat[g])
    );
  end

  // final window value includes the sample taken this cycle
  always_comb begin
    w_fin_sat = '0;
    for (int i = 0; i < 4; i++) begin
      w_fin[i] = w_acc[i];
      if (w_inc[i]) begin
        if (w_acc[i] == CNT_MAX) w_fin_sat[i] = 1'b1;
        else                     w_fin[i] = w_acc[i] + 1'b1;
      end
      w_fin_sat[i] = w_fin_sat[i] | w_acc_sat[i];
    end
  end

  // next quiet count: zero samples climb, any spike restarts
  always_comb begin
    w_qnext = '0;
    if (w_run && (cell_state == 4'b0000)) begin
      if (r_qcnt == QC_MAX) w_qnext = QC_MAX;
      else                  w_qnext = r_qcnt + 1'b1;
    end
  end

  // control FSM with window and quiet counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_qcnt  <= '0;
      r_quiet <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_wcnt  <= '0;
          r_qcnt  <= '0;
          r_quiet <= 1'b0;
          if (enable) r_state <= COUNT;
        end
        COUNT: begin
          if (!enable) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
            r_qcnt  <= '0;
            r_quiet <= 1'b0;
          end else begin
            r_wcnt  <= w_last ? '0 : r_wcnt + 1'b1;
            r_qcnt  <= w_qnext;
            r_quiet <= (w_qnext == QC_MAX);
          end
        end
      endcase
    end
  end

  // one-deep result buffer; a full unread buffer drops new windows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_dropped <= 1'b0;
      r_sat     <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else if (w_last) begin
      if (!r_valid || mon.out_ready) begin
        r_valid <= 1'b1;
        r_sat   <= w_fin_sat;
        for (int i = 0; i < 4; i++) r_cnt[i] <= w_fin[i];
      end else begin
        r_dropped <= 1'b1;
      end
    end else if (r_valid && mon.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign mon.out_valid = r_valid;
  assign mon.cnt0      = r_cnt[DIR_N];
  assign mon.cnt1      = r_cnt[DIR_E];
  assign mon.cnt2      = r_cnt[DIR_S];
  assign mon.cnt3      = r_cnt[DIR_W];
  assign mon.sat       = r_sat;
  assign dropped       = r_dropped;
  assign quiet         = r_quiet;

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Directed bench for lif_spike_monitor.
// Two instances: 8-bit/64-cycle and 4-bit/20-cycle.
module tb_lif_spike_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] cell_state;
  logic       rdy_a;
  logic       rdy_b;
  logic       dropped_a;
  logic       quiet_a;
  logic       dropped_b;
  logic       quiet_b;

  int errs   = 0;
  int checks = 0;

  lif_spike_monitor_if #(.CNT_W(8)) bus_a ();
  lif_spike_monitor_if #(.CNT_W(4)) bus_b ();

  assign bus_a.out_ready = rdy_a;
  assign bus_b.out_ready = rdy_b;

  lif_spike_monitor #(
    .CNT_W     (8),
    .WIN_LEN   (64),
    .QUIET_LEN (16)
  ) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cell_state (cell_state),
    .dropped    (dropped_a),
    .quiet      (quiet_a),
    .mon        (bus_a)
  );

  lif_spike_monitor #(
    .CNT_W     (4),
    .WIN_LEN   (20),
    .QUIET_LEN (4)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cell_state (cell_state),
    .dropped    (dropped_b),
    .quiet      (quiet_b),
    .mon        (bus_b)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    enable     = 1'b0;
    cell_state = 4'b0000;
    rdy_a      = 1'b0;
    rdy_b      = 1'b0;
    step(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errs++; $display("FAIL rst_valid got=%b exp=0", bus_a.out_valid);
    end
    checks++;
    if ({bus_a.cnt3, bus_a.cnt2, bus_a.cnt1, bus_a.cnt0} !== 32'h0) begin
      errs++; $display("FAIL rst_cnt got=%h exp=0",
        {bus_a.cnt3, bus_a.cnt2, bus_a.cnt1, bus_a.cnt0});
    end
    checks++;
    if ({bus_a.sat, dropped_a, quiet_a} !== 6'b0) begin
      errs++; $display("FAIL rst_flags got=%b exp=0",
        {bus_a.sat, dropped_a, quiet_a});
    end
  endtask

  task automatic test_window();
    do_reset();
    enable     = 1'b1;
    cell_state = 4'b0100;
    step(1);
    step(63);
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errs++; $display("FAIL win_early_valid got=%b exp=0", bus_a.out_valid);
    end
    step(1);
    checks++;
    if (bus_a.out_valid !== 1'b1) begin
      errs++; $display("FAIL win_valid got=%b exp=1", bus_a.out_valid);
    end
    checks++;
    if (bus_a.cnt2 !== 8'd64) begin
      errs++; $display("FAIL win_cnt2 got=%0d exp=64", bus_a.cnt2);
    end
    checks++;
    if ({bus_a.cnt3, bus_a.cnt1, bus_a.cnt0, bus_a.sat} !== 28'h0) begin
      errs++; $display("FAIL win_others got=%h exp=0",
        {bus_a.cnt3, bus_a.cnt1, bus_a.cnt0, bus_a.sat});
    end
  endtask

  task automatic test_saturate();
    do_reset();
    enable     = 1'b1;
    cell_state = 4'b1111;
    step(1);
    step(20);
    checks++;
    if (bus_b.out_valid !== 1'b1) begin
      errs++; $display("FAIL sat_valid got=%b exp=1", bus_b.out_valid);
    end
    checks++;
    if ({bus_b.cnt3, bus_b.cnt2, bus_b.cnt1, bus_b.cnt0} !== 16'hffff) begin
      errs++; $display("FAIL sat_cnt got=%h exp=ffff",
        {bus_b.cnt3, bus_b.cnt2, bus_b.cnt1, bus_b.cnt0});
    end
    checks++;
    if (bus_b.sat !== 4'b1111) begin
      errs++; $display("FAIL sat_flags got=%b exp=1111", bus_b.sat);
    end
    rdy_b      = 1'b1;
    cell_state = 4'b0001;
    step(1);
    rdy_b = 1'b0;
    checks++;
    if (bus_b.out_valid !== 1'b0) begin
      errs++; $display("FAIL sat_consume got=%b exp=0", bus_b.out_valid);
    end
    step(4);
    cell_state = 4'b0000;
    step(15);
    checks++;
    if ({bus_b.out_valid, bus_b.cnt3, bus_b.cnt2, bus_b.cnt1, bus_b.cnt0,
         bus_b.sat} !== {1'b1, 16'h0005, 4'b0000}) begin
      errs++; $display("FAIL sat_next got=%h exp=%h",
        {bus_b.out_valid, bus_b.cnt3, bus_b.cnt2, bus_b.cnt1, bus_b.cnt0,
         bus_b.sat}, {1'b1, 16'h0005, 4'b0000});
    end
  endtask

  task automatic test_drop();
    do_reset();
    enable     = 1'b1;
    cell_state = 4'b0001;
    step(1);
    step(64);
    checks++;
    if ({bus_a.out_valid, bus_a.cnt0} !== {1'b1, 8'd64}) begin
      errs++; $display("FAIL drop_first got=%h exp=%h",
        {bus_a.out_valid, bus_a.cnt0}, {1'b1, 8'd64});
    end
    cell_state = 4'b0010;
    step(64);
    checks++;
    if ({dropped_a, bus_a.out_valid, bus_a.cnt1, bus_a.cnt0} !==
        {2'b11, 8'd0, 8'd64}) begin
      errs++; $display("FAIL drop_hold got=%h exp=%h",
        {dropped_a, bus_a.out_valid, bus_a.cnt1, bus_a.cnt0},
        {2'b11, 8'd0, 8'd64});
    end
    cell_state = 4'b0100;
    step(63);
    rdy_a = 1'b1;
    step(1);
    rdy_a = 1'b0;
    checks++;
    if ({dropped_a, bus_a.out_valid, bus_a.cnt2, bus_a.cnt0} !==
        {2'b11, 8'd64, 8'd0}) begin
      errs++; $display("FAIL drop_reload got=%h exp=%h",
        {dropped_a, bus_a.out_valid, bus_a.cnt2, bus_a.cnt0},
        {2'b11, 8'd64, 8'd0});
    end
    step(1);
    checks++;
    if ({bus_a.out_valid, bus_a.cnt2} !== {1'b1, 8'd64}) begin
      errs++; $display("FAIL drop_stable got=%h exp=%h",
        {bus_a.out_valid, bus_a.cnt2}, {1'b1, 8'd64});
    end
    rdy_a = 1'b1;
    step(1);
    rdy_a = 1'b0;
    checks++;
    if ({bus_a.out_valid, bus_a.cnt2, dropped_a} !== {1'b0, 8'd64, 1'b1}) begin
      errs++; $display("FAIL drop_consume got=%h exp=%h",
        {bus_a.out_valid, bus_a.cnt2, dropped_a}, {1'b0, 8'd64, 1'b1});
    end
  endtask

  task automatic test_quiet();
    do_reset();
    enable     = 1'b1;
    cell_state = 4'b0000;
    step(1);
    step(15);
    checks++;
    if (quiet_a !== 1'b0) begin
      errs++; $display("FAIL quiet_15 got=%b exp=0", quiet_a);
    end
    step(1);
    checks++;
    if (quiet_a !== 1'b1) begin
      errs++; $display("FAIL quiet_16 got=%b exp=1", quiet_a);
    end
    cell_state = 4'b0001;
    step(1);
    checks++;
    if (quiet_a !== 1'b0) begin
      errs++; $display("FAIL quiet_spike got=%b exp=0", quiet_a);
    end
    cell_state = 4'b0000;
    step(15);
    checks++;
    if (quiet_a !== 1'b0) begin
      errs++; $display("FAIL quiet_re15 got=%b exp=0", quiet_a);
    end
    step(1);
    checks++;
    if (quiet_a !== 1'b1) begin
      errs++; $display("FAIL quiet_re16 got=%b exp=1", quiet_a);
    end
    enable = 1'b0;
    step(1);
    checks++;
    if (quiet_a !== 1'b0) begin
      errs++; $display("FAIL quiet_idle got=%b exp=0", quiet_a);
    end
  endtask

  task automatic test_abandon();
    do_reset();
    enable     = 1'b1;
    cell_state = 4'b1000;
    step(1);
    step(30);
    enable     = 1'b0;
    cell_state = 4'b0001;
    step(5);
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errs++; $display("FAIL abandon_partial got=%b exp=0", bus_a.out_valid);
    end
    enable = 1'b1;
    step(1);
    step(63);
    checks++;
    if (bus_a.out_valid !== 1'b0) begin
      errs++; $display("FAIL abandon_early got=%b exp=0", bus_a.out_valid);
    end
    step(1);
    checks++;
    if ({bus_a.out_valid, bus_a.cnt3, bus_a.cnt0} !== {1'b1, 8'd0, 8'd64}) begin
      errs++; $display("FAIL abandon_fresh got=%h exp=%h",
        {bus_a.out_valid, bus_a.cnt3, bus_a.cnt0}, {1'b1, 8'd0, 8'd64});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable     = 1'b1;
    cell_state = 4'b0100;
    step(1);
    step(64);
    step(10);
    checks++;
    if ({bus_a.out_valid, dropped_b} !== 2'b11) begin
      errs++; $display("FAIL arst_pre got=%b exp=11",
        {bus_a.out_valid, dropped_b});
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_a.out_valid, bus_a.cnt2, bus_a.sat, dropped_a, quiet_a} !==
        15'h0) begin
      errs++; $display("FAIL arst_a got=%h exp=0",
        {bus_a.out_valid, bus_a.cnt2, bus_a.sat, dropped_a, quiet_a});
    end
    checks++;
    if ({bus_b.out_valid, bus_b.cnt2, dropped_b} !== 6'h0) begin
      errs++; $display("FAIL arst_b got=%h exp=0",
        {bus_b.out_valid, bus_b.cnt2, dropped_b});
    end
    step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    cell_state = 4'b0000;
    rdy_a      = 1'b0;
    rdy_b      = 1'b0;
    step(1);
    test_reset();
    test_window();
    test_saturate();
    test_drop();
    test_quiet();
    test_abandon();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
